// File: rtl/device_mailbox_pkg.sv
// device_mailbox_pkg: shared cluster device-space definitions for the mailbox.
//   - device address width
//   - mailbox register offsets
//   - STATUS register bit positions
//   - read-data source selector
package device_mailbox_pkg;

  localparam int DEV_ADDR_W = 10;

  localparam logic [DEV_ADDR_W-1:0] MBOX_DEST     = 10'h000;
  localparam logic [DEV_ADDR_W-1:0] MBOX_SEND     = 10'h001;
  localparam logic [DEV_ADDR_W-1:0] MBOX_RECV     = 10'h002;
  localparam logic [DEV_ADDR_W-1:0] MBOX_STATUS   = 10'h003;
  localparam logic [DEV_ADDR_W-1:0] MBOX_CYCLE_LO = 10'h004;
  localparam logic [DEV_ADDR_W-1:0] MBOX_CYCLE_HI = 10'h005;

  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERFLOW  = 2;
  localparam int STAT_COUNT_LSB = 8;

  // Where device_data_in is taken from after a read cycle.
  typedef enum logic {
    RD_REG = 1'b0,
    RD_RAM = 1'b1
  } rd_src_e;

endpackage

// File: rtl/device_mailbox_storage.sv
// mailbox_storage: single-port RAM holding every inbox's words.
//   Address is {inbox id, pointer}. Read data is registered and only
//   changes on read-enabled cycles, so it holds until the next pop.
// Ports:
//   clk      clock
//   i_we     write enable
//   i_re     read enable
//   i_addr   word address
//   i_wdata  write data
//   o_rdata  registered read data
module mailbox_storage #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/device_mailbox.sv
// device_mailbox: memory-mapped inter-core mailbox on the cluster device port.
//   One inbox FIFO per core; any core pushes to its selected destination,
//   a core pops only its own inbox. At most one request per cycle.
//   Optional feature macro: MAILBOX_CYCLE_COUNTER_EN (32-bit cycle counter
//   at 0x004/0x005 with per-core upper-half snapshot).
// Ports:
//   clk              clock
//   reset            synchronous active-low reset
//   device_core_id   requesting core
//   device_write_en  write strobe
//   device_read_en   read strobe
//   device_addr      register offset
//   device_data_out  write data from the core
//   device_data_in   registered read data (1-cycle latency, holds otherwise)
module device_mailbox
  import device_mailbox_pkg::*;
#(
  parameter int NUM_CORES  = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            device_core_id,
  input  logic                  device_write_en,
  input  logic                  device_read_en,
  input  logic [DEV_ADDR_W-1:0] device_addr,
  input  logic [15:0]           device_data_out,
  output logic [15:0]           device_data_in
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int RAM_AW = 3 + PTR_W;

  logic [2:0]       r_dest  [NUM_CORES];
  logic [PTR_W-1:0] r_head  [NUM_CORES];
  logic [PTR_W-1:0] r_tail  [NUM_CORES];
  logic [CNT_W-1:0] r_count [NUM_CORES];
  logic             r_ovf   [NUM_CORES];
  logic [15:0]      r_rd_data;
  rd_src_e          r_rd_src;

  logic [2:0]        w_dst;
  logic              w_rd;
  logic              w_send;
  logic              w_send_ok;
  logic              w_pop;
  logic [15:0]       w_status;
  logic [15:0]       w_rd_val;
  logic [RAM_AW-1:0] w_ram_addr;
  logic [15:0]       w_ram_q;

`ifdef MAILBOX_CYCLE_COUNTER_EN
  logic [31:0] r_cycle;
  logic [15:0] r_snap [NUM_CORES];
`endif

  // A simultaneous write wins; the read half is treated as returning 0.
  assign w_rd      = device_read_en & ~device_write_en;
  assign w_dst     = r_dest[device_core_id];
  assign w_send    = device_write_en && (device_addr == MBOX_SEND);
  assign w_send_ok = w_send && (r_count[w_dst] != CNT_W'(FIFO_DEPTH));
  assign w_pop     = w_rd && (device_addr == MBOX_RECV) &&
                     (r_count[device_core_id] != '0);

  // Push and pop never coincide, so one RAM port serves both.
  assign w_ram_addr = w_send_ok ? {w_dst, r_tail[w_dst]}
                                : {device_core_id, r_head[device_core_id]};

  mailbox_storage #(
    .ADDR_W (RAM_AW),
    .DATA_W (16)
  ) u_storage (
    .clk     (clk),
    .i_we    (w_send_ok),
    .i_re    (w_pop),
    .i_addr  (w_ram_addr),
    .i_wdata (device_data_out),
    .o_rdata (w_ram_q)
  );

  always_comb begin
    w_status = '0;
    w_status[STAT_NOT_EMPTY] = (r_count[device_core_id] != '0);
    w_status[STAT_FULL]      = (r_count[device_core_id] == CNT_W'(FIFO_DEPTH));
    w_status[STAT_OVERFLOW]  = r_ovf[device_core_id];
    w_status[15:STAT_COUNT_LSB] = 8'(r_count[device_core_id]);
  end

  always_comb begin
    w_rd_val = '0;
    if (device_addr == MBOX_STATUS) w_rd_val = w_status;
`ifdef MAILBOX_CYCLE_COUNTER_EN
    if (device_addr == MBOX_CYCLE_LO) w_rd_val = r_cycle[15:0];
    if (device_addr == MBOX_CYCLE_HI) w_rd_val = r_snap[device_core_id];
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        r_dest[i]  <= '0;
        r_head[i]  <= '0;
        r_tail[i]  <= '0;
        r_count[i] <= '0;
        r_ovf[i]   <= 1'b0;
      end
      r_rd_data <= '0;
      r_rd_src  <= RD_REG;
    end else begin
      if (device_write_en && (device_addr == MBOX_DEST))
        r_dest[device_core_id] <= device_data_out[2:0];
      if (w_send_ok) begin
        r_tail[w_dst]  <= r_tail[w_dst] + 1'b1;
        r_count[w_dst] <= r_count[w_dst] + 1'b1;
      end else if (w_send) begin
        r_ovf[device_core_id] <= 1'b1;
      end
      if (device_write_en && (device_addr == MBOX_STATUS) &&
          device_data_out[STAT_OVERFLOW])
        r_ovf[device_core_id] <= 1'b0;
      if (w_pop) begin
        r_head[device_core_id]  <= r_head[device_core_id] + 1'b1;
        r_count[device_core_id] <= r_count[device_core_id] - 1'b1;
      end
      // RECV data arrives from the RAM register; everything else is
      // captured here. Both hold until the next read strobe.
      if (device_read_en) begin
        r_rd_data <= w_rd ? w_rd_val : '0;
        r_rd_src  <= w_pop ? RD_RAM : RD_REG;
      end
    end
  end

`ifdef MAILBOX_CYCLE_COUNTER_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cycle <= '0;
      for (int unsigned i = 0; i < NUM_CORES; i++) r_snap[i] <= '0;
    end else begin
      r_cycle <= r_cycle + 1'b1;
      if (w_rd && (device_addr == MBOX_CYCLE_LO))
        r_snap[device_core_id] <= r_cycle[31:16];
    end
  end
`endif

  assign device_data_in = (r_rd_src == RD_RAM) ? w_ram_q : r_rd_data;

endmodule

// File: tb/tb_device_mailbox.sv
module tb_device_mailbox;

  localparam int NC    = 8;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  device_core_id = '0;
  logic        device_write_en = 1'b0;
  logic        device_read_en = 1'b0;
  logic [9:0]  device_addr = '0;
  logic [15:0] device_data_out = '0;
  logic [15:0] device_data_in;

  device_mailbox #(.NUM_CORES(NC), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .device_core_id  (device_core_id),
    .device_write_en (device_write_en),
    .device_read_en  (device_read_en),
    .device_addr     (device_addr),
    .device_data_out (device_data_out),
    .device_data_in  (device_data_in)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: one queue per inbox plus per-core dest and overflow.
  logic [15:0] mq   [NC][$];
  int          mdst [NC];
  bit          movf [NC];
  logic [15:0] last_rd;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_clear();
    for (int c = 0; c < NC; c++) begin
      mq[c].delete();
      mdst[c] = 0;
      movf[c] = 1'b0;
    end
    last_rd = '0;
  endtask

  function automatic logic [15:0] m_read(input int id, input int addr);
    logic [15:0] v;
    v = '0;
    if (addr == 2) begin
      if (mq[id].size() > 0) v = mq[id].pop_front();
    end else if (addr == 3) begin
      v = {8'(mq[id].size()), 5'd0, movf[id], (mq[id].size() == DEPTH), (mq[id].size() != 0)};
    end
    return v;
  endfunction

  task automatic m_write(input int id, input int addr, input logic [15:0] d);
    if (addr == 0) mdst[id] = int'(d[2:0]);
    else if (addr == 1) begin
      if (mq[mdst[id]].size() == DEPTH) movf[id] = 1'b1;
      else mq[mdst[id]].push_back(d);
    end else if (addr == 3) begin
      if (d[2]) movf[id] = 1'b0;
    end
  endtask

  // One bus cycle, starting and ending at a falling edge. Output is checked
  // every cycle: fresh data after a read, the held value otherwise.
  task automatic op(input int id, input bit we, input bit re, input int addr,
                    input logic [15:0] d, input string tag);
    logic [15:0] exp;
    device_core_id  = 3'(id);
    device_write_en = we;
    device_read_en  = re;
    device_addr     = 10'(addr);
    device_data_out = d;
    exp = last_rd;
    if (re) exp = we ? 16'h0 : m_read(id, addr);
    if (we) m_write(id, addr, d);
    @(negedge clk);
    device_write_en = 1'b0;
    device_read_en  = 1'b0;
    if (re) last_rd = exp;
    chk(tag, device_data_in, exp);
  endtask

  task automatic wr(input int id, input int addr, input logic [15:0] d);
    op(id, 1'b1, 1'b0, addr, d, "write_hold");
  endtask

  task automatic rd(input int id, input int addr, input string tag);
    op(id, 1'b0, 1'b1, addr, 16'h0, tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(0, 1'b0, 1'b0, 0, 16'h0, "idle_hold");
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_clear();
    chk("reset_data_in", device_data_in, 16'h0000);
  endtask

  initial begin
    m_clear();
    @(negedge clk);
    do_reset();

    rd(0, 3, "rst_status");
    rd(0, 2, "rst_recv_empty");

    // Basic send/receive
    wr(2, 0, 16'h0005);
    wr(2, 1, 16'h1234);
    wr(2, 1, 16'hBEEF);
    rd(5, 3, "c5_status_2");
    rd(5, 2, "c5_recv_1");
    idle(2);
    rd(5, 2, "c5_recv_2");
    rd(5, 3, "c5_status_0");
    rd(5, 0, "dest_wo_reads0");
    rd(5, 1, "send_wo_reads0");

    // Overflow
    wr(1, 0, 16'hFFF3);
    for (int i = 0; i < 9; i++) wr(1, 1, 16'h0100 + 16'(i));
    rd(3, 3, "c3_status_full");
    rd(1, 3, "c1_status_ovf");
    for (int i = 0; i < 8; i++) rd(3, 2, "c3_drain");
    rd(3, 2, "c3_recv_empty");
    wr(1, 3, 16'h0004);
    rd(1, 3, "c1_ovf_cleared");

    // Pointer wrap on inbox 7
    wr(6, 0, 16'h0007);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) wr(6, 1, 16'(16'h7000 + r * 16'h100 + i));
      rd(7, 3, "c7_wrap_full");
      for (int i = 0; i < DEPTH; i++) rd(7, 2, "c7_wrap_recv");
    end

    // Self-send
    wr(4, 0, 16'h0004);
    wr(4, 1, 16'h4444);
    rd(4, 2, "self_recv");

    // Mid-operation reset
    wr(0, 0, 16'h0004);
    for (int i = 0; i < 4; i++) wr(0, 1, 16'hC000 + 16'(i));
    rd(4, 3, "c4_status_pre");
    do_reset();
    rd(4, 3, "c4_status_post");
    for (int c = 0; c < NC; c++) wr(c, 1, 16'hA000 + 16'(c));
    rd(0, 3, "c0_status_dest0");
    for (int i = 0; i < NC; i++) rd(0, 2, "c0_dest0_recv");

    // Simultaneous read and write
    wr(3, 0, 16'h0002);
    op(3, 1'b1, 1'b1, 1, 16'h5A5A, "rw_both_send");
    op(2, 1'b1, 1'b1, 2, 16'h0000, "rw_both_recv");
    rd(2, 2, "rw_both_after");

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int id, addr, sel;
      bit we, re;
      id  = int'($urandom_range(0, NC - 1));
      sel = int'($urandom_range(0, 99));
`ifdef MAILBOX_CYCLE_COUNTER_EN
      addr = int'($urandom_range(0, 3));
`else
      addr = (sel < 5) ? int'($urandom_range(4, 1023)) : int'($urandom_range(0, 5));
`endif
      sel = int'($urandom_range(0, 99));
      we = (sel < 45) || (sel >= 95);
      re = (sel >= 45 && sel < 90) || (sel >= 95);
      if (addr == 1 && sel < 45) addr = ($urandom_range(0, 1) == 0) ? 1 : 0;
      op(id, we, re, addr, 16'($urandom()), "rand");
    end

`ifdef MAILBOX_CYCLE_COUNTER_EN
    begin
      logic [15:0] a, b;
      rd(2, 4, "cyc_lo_first");
      a = last_rd;
      idle(9);
      rd(2, 4, "cyc_lo_second");
      b = last_rd;
      chk("cyc_delta10", b - a, 16'd10);
      dut.r_cycle = 32'h0000_FFFD;
      op(6, 1'b0, 1'b1, 4, 16'h0, "dummy_lo");
      chk("cyc_lo_fffd", device_data_in, 16'hFFFD);
      op(6, 1'b0, 1'b1, 5, 16'h0, "dummy_hi");
      chk("cyc_hi_0000", device_data_in, 16'h0000);
      op(6, 1'b0, 1'b1, 4, 16'h0, "dummy_lo");
      chk("cyc_lo_ffff", device_data_in, 16'hFFFF);
      op(6, 1'b0, 1'b1, 5, 16'h0, "dummy_hi");
      chk("cyc_hi_0000b", device_data_in, 16'h0000);
      op(6, 1'b0, 1'b1, 4, 16'h0, "dummy_lo");
      chk("cyc_lo_0001", device_data_in, 16'h0001);
      op(6, 1'b0, 1'b1, 5, 16'h0, "dummy_hi");
      chk("cyc_hi_0001", device_data_in, 16'h0001);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/device_mailbox.md
# device_mailbox

Memory-mapped inter-core mailbox that sits on the cluster's device port as the responder to the cores' device reads and writes. Each core owns one inbox FIFO. Any core can push a 16-bit word into any core's inbox. A core pops only from its own inbox. The cluster arbitrates one core per cycle, so the block sees at most one request per cycle and needs no internal arbitration.

## Interface
- NUM_CORES, 8, number of cores and inboxes; must be 8 to match the 3-bit core id.
- FIFO_DEPTH, 8, words per inbox; power of two, at least 2.
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset.
- device_core_id  input  3  id of the core owning the current request.
- device_write_en  input  1  write strobe for the current cycle.
- device_read_en  input  1  read strobe for the current cycle.
- device_addr  input  10  register offset within device space.
- device_data_out  input  16  write data from the core.
- device_data_in  output  16  registered read data.

## Operation
- Register map (offsets in device_addr):
  - 0x000 DEST: write only.
    - Writes data[2:0] into dest[device_core_id].
    - Upper data bits are ignored.
  - 0x001 SEND: write only.
    - Pushes data into the inbox of dest[device_core_id].
    - If that inbox is full, the word is dropped and the sender's overflow flag is set.
  - 0x002 RECV: read only.
    - Pops the head of inbox[device_core_id] and returns it.
    - If the inbox is empty, returns 0 and leaves the pointers unchanged.
  - 0x003 STATUS: read and write, for the requesting core.
    - Read format: bit0 = inbox not empty, bit1 = inbox full, bit2 = sender overflow flag, bits[15:8] = inbox count, other bits 0.
    - Writing with bit2 = 1 clears that core's overflow flag. Other bits are ignored.
  - 0x004 / 0x005: cycle counter; see Configuration.
- Unmapped offsets, and reads of write-only registers, return 0. Writes to them have no effect.
- Per-inbox state:
  - head and tail pointers, each log2(FIFO_DEPTH) bits, wrapping modulo FIFO_DEPTH.
  - count, log2(FIFO_DEPTH)+1 bits.
  - full when count == FIFO_DEPTH; empty when count == 0.
- A core may send to itself; this is a normal push into its own inbox.
- If read_en and write_en are both asserted in one cycle, the write is performed and the read returns 0. The bus never produces this; it is defined for robustness.

## Timing
- Read latency is exactly 1 cycle: device_data_in is valid on the cycle after device_read_en, which is where the cluster samples it.
- device_data_in updates only on cycles with read_en. Otherwise it holds its previous value.
- A SEND is visible to the receiver's RECV and STATUS on the next cycle.
- A RECV pop takes effect at the end of the request cycle.
- Reset (reset == 0 at a clock edge):
  - all pointers, counts and overflow flags cleared;
  - dest[] = 0 for every core;
  - device_data_in = 0;
  - cycle counter = 0.
- Reset mid-operation discards all queued words. Stored memory contents need not be cleared.

## Configuration
- MAILBOX_CYCLE_COUNTER_EN defined:
  - A 32-bit free-running counter increments every cycle and wraps at 2^32.
  - Reading 0x004 returns bits[15:0] and latches bits[31:16] into a per-core snapshot register.
  - Reading 0x005 returns that core's snapshot.
  - Snapshot reset value is 0.
- MAILBOX_CYCLE_COUNTER_EN undefined: 0x004 and 0x005 behave as unmapped, and no counter logic exists.

## Structure
- Shared cluster defines package holds:
  - register offset constants (MBOX_DEST, MBOX_SEND, MBOX_RECV, MBOX_STATUS, MBOX_CYCLE_LO, MBOX_CYCLE_HI);
  - STATUS bit positions;
  - the device address width (10).
- One sub-module, mailbox_storage: a NUM_CORES*FIFO_DEPTH x 16 single-port RAM.
  - Address is {inbox id, pointer}.
  - 1-cycle registered read, which directly provides the RECV latency.
  - Pointer and count logic stays in device_mailbox.

## Test plan
- Reset, then core 0 reads STATUS -> 0x0000. Core 0 reads RECV -> 0x0000.
- Core 2 writes DEST=5, then SEND 0x1234 and SEND 0xBEEF. Core 5 reads STATUS -> 0x0201. Two RECVs return 0x1234 then 0xBEEF. STATUS then reads 0x0000.
- Core 1 writes DEST=3 and sends 9 words 0x0100..0x0108:
  - core 3 STATUS -> 0x0803;
  - core 1 STATUS -> bit2 set;
  - core 3 receives 0x0100..0x0107;
  - core 1 writes STATUS=0x0004 -> bit2 clears.
- Wrap-around: repeat fill/drain of inbox 7 three times with distinct data. FIFO order is preserved across pointer wrap.
- Mid-operation reset: queue 4 words to inbox 4, pulse reset low for 1 cycle -> inbox 4 STATUS 0x0000, and dest of every core is 0.
- With MAILBOX_CYCLE_COUNTER_EN: two reads of 0x004 spaced 10 cycles apart differ by 10. Force the counter near 0x0000FFFF -> 0x005 returns the latched upper half consistent with the preceding low read.
